regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised 2-read/1-write register file for the pipelined MIPS datapath.
//  - Reset-driven init sequencer loads mem[i] = i, then raises ready.
//  - Reads are registered on posedge; writes land at posedge.
//  - Optional same-cycle write-to-read bypass (see CONFIGURATION).
//  - Also provides a combinational debug read port for testbench and waveform probing.
// PARAMETERS
//  WIDTH     32  data width in bits
//  DEPTH     32  number of registers, >= 2
//  ZERO_REG  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is an ordinary register
//  AW        $clog2(DEPTH)  address width (derived localparam, not overridable)
// PORTS
//  clk        in   1      clock; all state changes on the posedge
//  rst_n      in   1      asynchronous, active-low reset
//  rd_en      in   1      capture a new read on this posedge
//  rd_addr_a  in   AW     read address, port A (Rs)
//  rd_addr_b  in   AW     read address, port B (Rt)
//  rd_data_a  out  WIDTH  registered read data, port A
//  rd_data_b  out  WIDTH  registered read data, port B
//  wr_en      in   1      write enable (WB RegWrite)
//  wr_addr    in   AW     write address (WB destination register)
//  wr_data    in   WIDTH  write data (WB data)
//  dbg_addr   in   AW     debug read address
//  dbg_data   out  WIDTH  combinational mem[dbg_addr]
//  ready      out  1      1 = init done, normal operation
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately, independent of clk):
//   - state=INIT, cnt=0, ready=0, rd_data_a=rd_data_b=0.
//   - mem contents are not cleared by reset; the INIT sequencer rewrites them.
//  INIT state (after rst_n release):
//   - Each posedge: mem[cnt] <= cnt zero-extended to WIDTH; cnt <= cnt+1.
//   - If ZERO_REG=1, mem[0] is written 0.
//   - After the posedge that writes cnt==DEPTH-1: state=RUN, ready=1.
//   - ready therefore rises exactly DEPTH posedges after reset release.
//   - wr_en and rd_en are ignored; rd_data_a/b hold 0.
//  RUN state:
//   - Write: wr_en=1 -> mem[wr_addr] <= wr_data at posedge.
//     - Dropped if ZERO_REG=1 and wr_addr==0.
//     - Dropped if wr_addr >= DEPTH.
//   - Read: rd_en=1 -> rd_data_x <= mem[rd_addr_x] at posedge (1-cycle latency).
//     - rd_en=0 holds the previous rd_data_x.
//     - Address 0 with ZERO_REG=1, or address >= DEPTH, returns 0.
//   - Read of the address written on the same posedge: result per CONFIGURATION.
//   - Both ports may read the same address; both return the identical value.
//   - RUN is terminal until the next reset; a reset mid-RUN restarts INIT.
//  dbg_data: combinational from mem.
//   - Returns 0 for address >= DEPTH.
//   - Not affected by the bypass.
//   - Shows sequencer progress during INIT.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - RUN, rd_en=1, wr_en=1, rd_addr_x==wr_addr, write not dropped -> rd_data_x <= wr_data (write-first).
//   - Removes the WB->ID hazard, replacing the old negedge-read scheme.
//  REGFILE_BYPASS_EN undefined:
//   - rd_data_x <= old mem value (read-first).
//   - The new value is visible to the next read.
// TESTING
//  1 Reset, release, DEPTH=32 -> ready=0 for 31 posedges, 1 on the 32nd; after that, dbg_addr=7 gives dbg_data=7.
//  2 RUN: wr_en=1, wr_addr=4, wr_data=16; next cycle rd_en=1, rd_addr_a=4 -> rd_data_a=16 one posedge later.
//  3 wr_en=1, wr_addr=0, wr_data=0xFFFF; then read address 0 -> rd_data=0 (ZERO_REG=1).
//  4 Same posedge: wr 5<-0xAB, read A=5, B=5 -> 0xAB on both with REGFILE_BYPASS_EN; 5 on both without.
//  5 rd_en=0 while rd_addr changes -> rd_data_a/b hold their previous values.
//  6 Pull rst_n low mid-RUN between edges -> rd_data=0 and ready=0 immediately; INIT restores mem[4]=4.

Source files
------------

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, write port, debug port and ready.
// master drives requests (datapath/bench), slave is the register file.
interface regfile_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             rd_en;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic             ready;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data, ready
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data, ready
    );
endinterface

// File: rtl/regfile_param.sv
// 2-read/1-write register file with reset-driven init sequencer (mem[i] = i).
// Optional macro REGFILE_BYPASS_EN: same-edge write-to-read bypass (write-first).
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_param_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             wr_take;
    logic [WIDTH-1:0] rd_a_d, rd_b_d;
    logic [WIDTH-1:0] rd_a_q, rd_b_q;
    logic [WIDTH-1:0] dbg_d;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic addr_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port: sequencer owns the array during INIT, WB port during RUN
    // ------------------------------------------------------------------
    always_comb begin
        wr_take = (state_q == S_RUN) && bus.wr_en &&
                  addr_ok(bus.wr_addr) && !addr_zero(bus.wr_addr);
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == S_INIT) begin
            // gated by rst_n so a held reset does not keep rewriting mem[0]
            mem_we    = rst_n;
            mem_waddr = cnt_q;
            mem_wdata = addr_zero(cnt_q) ? '0 : WIDTH'(cnt_q);
        end else begin
            mem_we    = wr_take;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports
    // ------------------------------------------------------------------
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        if (addr_ok(bus.rd_addr_a) && !addr_zero(bus.rd_addr_a)) begin
            rd_a_d = mem[bus.rd_addr_a];
        end
        if (addr_ok(bus.rd_addr_b) && !addr_zero(bus.rd_addr_b)) begin
            rd_b_d = mem[bus.rd_addr_b];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_take already excludes dropped writes, so reg 0 never bypasses
        if (wr_take && (bus.rd_addr_a == bus.wr_addr)) begin
            rd_a_d = bus.wr_data;
        end
        if (wr_take && (bus.rd_addr_b == bus.wr_addr)) begin
            rd_b_d = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else if ((state_q == S_RUN) && bus.rd_en) begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Debug port and status
    // ------------------------------------------------------------------
    always_comb begin
        dbg_d = '0;
        if (addr_ok(bus.dbg_addr)) begin
            dbg_d = mem[bus.dbg_addr];
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.dbg_data  = dbg_d;
    assign bus.ready     = (state_q == S_RUN);

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param (WIDTH=32, DEPTH=32, ZERO_REG=1).
// Read expectations are queued at issue and checked by a negedge monitor.
module tb_regfile_param;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic rd_valid;

    // A read is presented one edge after it is accepted in RUN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_valid <= 1'b0;
        else        rd_valid <= bus.rd_en && bus.ready;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: a=%h b=%h with empty scoreboard",
                         bus.rd_data_a, bus.rd_data_b);
            end else begin
                e = sb.pop_front();
                total++;
                if (bus.rd_data_a !== e.ea) begin
                    bad++;
                    $display("FAIL %s_a: got %h want %h", e.name, bus.rd_data_a, e.ea);
                end
                total++;
                if (bus.rd_data_b !== e.eb) begin
                    bad++;
                    $display("FAIL %s_b: got %h want %h", e.name, bus.rd_data_b, e.eb);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        exp_t e;
        e.name = name;
        e.ea   = ea;
        e.eb   = eb;
        bus.rd_en     = 1'b1;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        sb.push_back(e);
        cycle();
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic [WIDTH-1:0] same_exp;

        bus.rd_en = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.dbg_addr = 5'd9;

        // reset state
        #2;
        check("rst_rd_a",  bus.rd_data_a, 32'h0);
        check("rst_rd_b",  bus.rd_data_b, 32'h0);
        check("rst_ready", WIDTH'(bus.ready), 32'h0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // ready must rise exactly on the 32nd posedge after release
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            check($sformatf("init_ready_%0d", i), WIDTH'(bus.ready), (i == DEPTH) ? 32'h1 : 32'h0);
            if (i == 10) check("init_dbg_9", bus.dbg_data, 32'd9);
        end
        bus.dbg_addr = 5'd7;
        #1;
        check("dbg_7", bus.dbg_data, 32'd7);

        // write then read back
        wr(5'd4, 32'd16);
        bus.dbg_addr = 5'd4;
        #1;
        check("dbg_4", bus.dbg_data, 32'd16);
        rd("wr4_rd", 5'd4, 5'd7, 32'd16, 32'd7);

        // register 0 ignores writes and reads 0
        wr(5'd0, 32'hFFFF);
        rd("zero_rd", 5'd0, 5'd0, 32'h0, 32'h0);
        bus.dbg_addr = 5'd0;
        #1;
        check("dbg_0", bus.dbg_data, 32'h0);

        // same-edge write/read, both ports on the same address
`ifdef REGFILE_BYPASS_EN
        same_exp = 32'hAB;
`else
        same_exp = 32'd5;
`endif
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hAB;
        rd("same_edge", 5'd5, 5'd5, same_exp, same_exp);
        bus.wr_en = 1'b0;
        rd("after_same", 5'd5, 5'd5, 32'hAB, 32'hAB);

        // same-edge write to reg 0 never bypasses
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h5A5A;
        rd("zero_same_edge", 5'd0, 5'd9, 32'h0, 32'd9);
        bus.wr_en = 1'b0;

        // wr_en low must not write
        bus.wr_addr = 5'd6; bus.wr_data = 32'd99;
        cycle();
        rd("no_wr_en", 5'd6, 5'd31, 32'd6, 32'd31);

        // rd_en low holds previous data while addresses change
        rd("pre_hold", 5'd4, 5'd31, 32'd16, 32'd31);
        bus.rd_addr_a = 5'd1; bus.rd_addr_b = 5'd2;
        cycle();
        cycle();
        cycle();
        check("hold_a", bus.rd_data_a, 32'd16);
        check("hold_b", bus.rd_data_b, 32'd31);

        // asynchronous reset mid-RUN between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_a",  bus.rd_data_a, 32'h0);
        check("arst_rd_b",  bus.rd_data_b, 32'h0);
        check("arst_ready", WIDTH'(bus.ready), 32'h0);
        cycle();
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 40) begin
            cycle();
            n++;
        end
        check("reinit_cycles", n, 32'd32);
        rd("reinit_rd", 5'd4, 5'd0, 32'd4, 32'h0);

        cycle();
        cycle();
        check("sb_drained", WIDTH'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
